// File: rtl/fast_cmd_gen.sv
// ============================================================================
// fast_cmd_gen
// ----------------------------------------------------------------------------
// Fast-command generator for the module emulator. Serialises 8-bit
// fast-command frames MSB-first on the 320 MHz bit clock, one frame per
// 40 MHz bunch crossing. Every frame is picked at the frame boundary from,
// in priority order:
//   1. BCR_CODE when the upcoming frame is the BCR bunch crossing
//   2. L0L1_CODE when at least one trigger request is pending
//   3. the head of the user command FIFO (optional, see below)
//   4. IDLE_CODE
// While 'enable' is low every frame is IDLE and the orbit counter rests at 0.
//
// Optional feature:
//   FAST_CMD_USER_FIFO_EN  defined   -> user command FIFO built, rule 3 active
//                          undefined -> no FIFO, cmd_ready tied low,
//                                       cmd_valid/cmd_data ignored
//
// Ports:
//   clk320           in   320 MHz bit clock
//   LPGBT_HARD_RSTB  in   asynchronous active-low reset
//   enable           in   1 = orbit sequencing, 0 = IDLE frames only
//                         (sampled at frame boundaries only)
//   trig_i           in   single-cycle trigger request
//   cmd_valid        in   user command write strobe
//   cmd_data         in   user command byte
//   cmd_ready        out  user FIFO can accept a byte
//   fast_cmd_out     out  serial command bit (registered)
//   frame_start      out  high while fast_cmd_out carries bit 7 of a frame
//   bc_cnt           out  bunch-crossing number of the frame on fast_cmd_out
//   trig_drop        out  one-cycle pulse when a trigger request was lost
// ============================================================================
module fast_cmd_gen #(
    parameter logic [7:0] IDLE_CODE  = 8'hAC,
    parameter logic [7:0] L0L1_CODE  = 8'hB2,
    parameter logic [7:0] BCR_CODE   = 8'h99,
    parameter int         ORBIT_LEN  = 3564,
    parameter int         BCR_BC     = 0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                         clk320,
    input  logic                         LPGBT_HARD_RSTB,
    input  logic                         enable,
    input  logic                         trig_i,
    input  logic                         cmd_valid,
    input  logic [7:0]                   cmd_data,
    output logic                         cmd_ready,
    output logic                         fast_cmd_out,
    output logic                         frame_start,
    output logic [$clog2(ORBIT_LEN)-1:0] bc_cnt,
    output logic                         trig_drop
);

    localparam int              BC_W    = $clog2(ORBIT_LEN);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(ORBIT_LEN - 1);
    localparam logic [BC_W-1:0] BC_BCR  = BC_W'(BCR_BC);

    // ------------------------------------------------------------------------
    // Frame timing and shift state
    // ------------------------------------------------------------------------
    logic [2:0]      bit_cnt;     // position inside the frame being shifted
    logic [7:0]      shift_reg;   // frame being shifted out, MSB next
    logic [BC_W-1:0] frame_bc;    // bunch crossing of the frame in shift_reg
    logic            run;         // enable as sampled at the last boundary
    logic            boundary;    // this edge loads the next frame

    // ------------------------------------------------------------------------
    // Frame selection
    // ------------------------------------------------------------------------
    logic [BC_W-1:0] next_bc;
    logic            bcr_slot;
    logic [7:0]      next_frame;
    logic            take_trig;
    logic            consume;

    // ------------------------------------------------------------------------
    // Trigger bookkeeping
    // ------------------------------------------------------------------------
    logic [1:0]      pending;
    logic            trig_acc;

    assign boundary = (bit_cnt == 3'd7);

    // Triggers only count while the previous boundary saw enable high, so a
    // disabled generator neither queues nor drops them.
    assign trig_acc = trig_i && run;

`ifdef FAST_CMD_USER_FIFO_EN
    // ------------------------------------------------------------------------
    // User command FIFO
    // ------------------------------------------------------------------------
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic             take_user;

    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_pop   = boundary && take_user;
    assign fifo_head  = fifo_mem[rd_ptr];

    // Storage needs no reset: the pointers and count define what is valid,
    // and FIFO_DEPTH being a power of two lets the pointers wrap by overflow.
    always_ff @(posedge clk320) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= cmd_data;
        end
    end

    // Pointer and occupancy tracking. A push and a pop on the same edge
    // leave the occupancy unchanged.
    always_ff @(posedge clk320 or negedge LPGBT_HARD_RSTB) begin
        if (!LPGBT_HARD_RSTB) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
`else
    // Without the FIFO the command inputs are intentionally left dangling.
    localparam int unused_fifo_depth = FIFO_DEPTH;
    logic unused_cmd_inputs;

    assign unused_cmd_inputs = ^{cmd_valid, cmd_data};
    assign cmd_ready         = 1'b0;
`endif

    // Choose the frame to load at the next boundary. The upcoming bunch
    // crossing restarts at 0 both while disabled and on the first enabled
    // frame after a disabled one, so an orbit always begins cleanly.
    always_comb begin
        next_bc    = '0;
        next_frame = IDLE_CODE;
        take_trig  = 1'b0;
`ifdef FAST_CMD_USER_FIFO_EN
        take_user  = 1'b0;
`endif
        if (enable && run) begin
            next_bc = (frame_bc == BC_LAST) ? '0 : frame_bc + BC_W'(1);
        end
        bcr_slot = enable && (next_bc == BC_BCR);
        if (enable) begin
            if (bcr_slot) begin
                next_frame = BCR_CODE;
            end else if (pending != 2'd0) begin
                next_frame = L0L1_CODE;
                take_trig  = 1'b1;
`ifdef FAST_CMD_USER_FIFO_EN
            end else if (!fifo_empty) begin
                next_frame = fifo_head;
                take_user  = 1'b1;
`endif
            end
        end
    end

    assign consume = boundary && take_trig;

    // Trigger pending counter. It saturates at 3; a request that arrives at
    // saturation without a same-edge L0L1 load is lost and flagged one cycle
    // later. A request arriving with a load leaves the count unchanged. A
    // BCR slot simply skips consumption, deferring triggers by one frame.
    // Disabling the generator discards queued triggers so that stale requests
    // never fire when sequencing resumes.
    always_ff @(posedge clk320 or negedge LPGBT_HARD_RSTB) begin
        if (!LPGBT_HARD_RSTB) begin
            pending   <= 2'd0;
            trig_drop <= 1'b0;
        end else begin
            trig_drop <= trig_acc && (pending == 2'd3) && !consume;
            if (boundary && !enable) begin
                pending <= 2'd0;
            end else if (trig_acc && !consume) begin
                if (pending != 2'd3) begin
                    pending <= pending + 2'd1;
                end
            end else if (!trig_acc && consume) begin
                pending <= pending - 2'd1;
            end
        end
    end

    // Bit counter and frame shift register. The reset value of the shift
    // register is IDLE, so the first frame after reset is always IDLE.
    always_ff @(posedge clk320 or negedge LPGBT_HARD_RSTB) begin
        if (!LPGBT_HARD_RSTB) begin
            bit_cnt   <= 3'd0;
            shift_reg <= IDLE_CODE;
            frame_bc  <= '0;
            run       <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (boundary) begin
                shift_reg <= next_frame;
                frame_bc  <= next_bc;
                run       <= enable;
            end else begin
                shift_reg <= {shift_reg[6:0], 1'b0};
            end
        end
    end

    // Registered serial outputs. bc_cnt follows frame_bc with the same one
    // cycle delay as the data bit, so it always labels the bit on the wire.
    always_ff @(posedge clk320 or negedge LPGBT_HARD_RSTB) begin
        if (!LPGBT_HARD_RSTB) begin
            fast_cmd_out <= 1'b0;
            frame_start  <= 1'b0;
            bc_cnt       <= '0;
        end else begin
            fast_cmd_out <= shift_reg[7];
            frame_start  <= (bit_cnt == 3'd0);
            bc_cnt       <= frame_bc;
        end
    end

endmodule

// File: tb/tb_fast_cmd_gen.sv
// ============================================================================
// tb_fast_cmd_gen
// ----------------------------------------------------------------------------
// Bench for fast_cmd_gen with a 16-frame orbit and BCR at bunch crossing 0.
// The stimulus process drives one frame period at a time and queues the
// frame it expects to see on the wire; the monitor reassembles each serial
// frame and compares it with the head of the queue.
// ============================================================================
module tb_fast_cmd_gen;

    localparam logic [7:0] IDLE = 8'hAC;
    localparam logic [7:0] L0L1 = 8'hB2;
    localparam logic [7:0] BCR  = 8'h99;

`ifdef FAST_CMD_USER_FIFO_EN
    localparam logic FIFO_EN = 1'b1;
`else
    localparam logic FIFO_EN = 1'b0;
`endif

    logic       clk320 = 1'b0;
    logic       LPGBT_HARD_RSTB;
    logic       enable;
    logic       trig_i;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       fast_cmd_out;
    logic       frame_start;
    logic [3:0] bc_cnt;
    logic       trig_drop;

    typedef struct {
        logic [7:0] code;
        logic [3:0] bc;
        int         drops;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    always #5 clk320 = ~clk320;

    fast_cmd_gen #(
        .IDLE_CODE (IDLE),
        .L0L1_CODE (L0L1),
        .BCR_CODE  (BCR),
        .ORBIT_LEN (16),
        .BCR_BC    (0),
        .FIFO_DEPTH(4)
    ) dut (
        .clk320         (clk320),
        .LPGBT_HARD_RSTB(LPGBT_HARD_RSTB),
        .enable         (enable),
        .trig_i         (trig_i),
        .cmd_valid      (cmd_valid),
        .cmd_data       (cmd_data),
        .cmd_ready      (cmd_ready),
        .fast_cmd_out   (fast_cmd_out),
        .frame_start    (frame_start),
        .bc_cnt         (bc_cnt),
        .trig_drop      (trig_drop)
    );

    // Single comparison point for every check in the bench.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one frame period (8 bit clocks, starting at the negedge before
    // the frame's first bit) and queue the frame expected on the wire.
    // trig_mask bit j raises trig_i for the j-th edge of the period; enable
    // matters only on the last edge, which selects the following frame.
    task automatic apply_stimulus(input logic [7:0] code, input logic [3:0] bc,
                                  input int drops, input logic en,
                                  input logic [7:0] trig_mask);
        exp_t e;
        e.code  = code;
        e.bc    = bc;
        e.drops = drops;
        sb.push_back(e);
        for (int j = 0; j < 8; j++) begin
            enable = en;
            trig_i = trig_mask[j];
            @(negedge clk320);
        end
        trig_i = 1'b0;
    endtask

    // Monitor: rebuild frames bit by bit, checking code, bunch crossing and
    // the number of trig_drop cycles seen while the frame was on the wire.
    int         mon_idx   = 0;
    int         mon_drops = 0;
    logic [7:0] mon_bits  = 8'h00;
    logic [3:0] mon_bc    = 4'h0;
    exp_t       mon_exp;

    always @(negedge clk320) begin
        if (!LPGBT_HARD_RSTB) begin
            mon_idx   = 0;
            mon_drops = 0;
        end else if (mon_idx != 0 || frame_start) begin
            if (mon_idx == 0) begin
                mon_bc    = bc_cnt;
                mon_drops = 0;
            end else if (frame_start) begin
                checks++;
                fails++;
                $display("[TB] FAIL frame_align: frame_start at bit slot %0d, expected slot 0 at %0t",
                         mon_idx, $time);
            end
            mon_bits  = {mon_bits[6:0], fast_cmd_out};
            mon_drops = mon_drops + int'(trig_drop);
            mon_idx++;
            if (mon_idx == 8) begin
                mon_idx = 0;
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_frame: got 0x%0h, expected no frame at %0t",
                             mon_bits, $time);
                end else begin
                    mon_exp = sb.pop_front();
                    check_output("frame_code", mon_bits, mon_exp.code);
                    check_output("frame_bc", mon_bc, mon_exp.bc);
                    check_output("trig_drop_count", mon_drops, mon_exp.drops);
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [7:0] wr_bytes [5];

    initial begin
        LPGBT_HARD_RSTB = 1'b0;
        enable          = 1'b0;
        trig_i          = 1'b0;
        cmd_valid       = 1'b0;
        cmd_data        = 8'h00;
        wr_bytes        = '{8'h5A, 8'h3C, 8'hF0, 8'h0F, 8'h77};

        // Reset state
        repeat (3) @(negedge clk320);
        check_output("rst_fast_cmd_out", fast_cmd_out, 0);
        check_output("rst_frame_start", frame_start, 0);
        check_output("rst_bc_cnt", bc_cnt, 0);
        check_output("rst_trig_drop", trig_drop, 0);
        check_output("rst_cmd_ready", cmd_ready, FIFO_EN);

        // Disabled: 64 IDLE frames at bc 0; a trigger in frame 10 is ignored.
        // Enable is raised for the boundary closing frame 63.
        LPGBT_HARD_RSTB = 1'b1;
        $display("[TB] disabled stream");
        for (int f = 0; f < 64; f++) begin
            apply_stimulus(IDLE, 4'd0, 0, (f == 63), (f == 10) ? 8'h10 : 8'h00);
        end

        // Two full orbits: BCR only on bc 0.
        $display("[TB] orbit sequencing");
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < 16; b++) begin
                apply_stimulus((b == 0) ? BCR : IDLE, 4'(b), 0, 1'b1, 8'h00);
            end
        end

        // Single trigger mid-frame, then a trigger deferred by the BCR slot.
        $display("[TB] triggers");
        apply_stimulus(BCR,  4'd0, 0, 1'b1, 8'h00);
        apply_stimulus(IDLE, 4'd1, 0, 1'b1, 8'h08);
        apply_stimulus(L0L1, 4'd2, 0, 1'b1, 8'h00);
        for (int b = 3; b < 15; b++) begin
            apply_stimulus(IDLE, 4'(b), 0, 1'b1, 8'h00);
        end
        apply_stimulus(IDLE, 4'd15, 0, 1'b1, 8'h08);
        apply_stimulus(BCR,  4'd0,  0, 1'b1, 8'h00);
        apply_stimulus(L0L1, 4'd1,  0, 1'b1, 8'h00);
        apply_stimulus(IDLE, 4'd2,  0, 1'b1, 8'h00);
        apply_stimulus(IDLE, 4'd3,  0, 1'b1, 8'h00);

        // Five triggers in one frame: three L0L1 frames, two drops.
        apply_stimulus(IDLE, 4'd4, 2, 1'b1, 8'h3E);
        apply_stimulus(L0L1, 4'd5, 0, 1'b1, 8'h00);
        apply_stimulus(L0L1, 4'd6, 0, 1'b1, 8'h00);
        apply_stimulus(L0L1, 4'd7, 0, 1'b1, 8'h00);
        apply_stimulus(IDLE, 4'd8, 0, 1'b1, 8'h00);

        // User commands: five back-to-back writes into a 4-entry FIFO.
        $display("[TB] user commands");
        begin
            exp_t e;
            e.code  = IDLE;
            e.bc    = 4'd9;
            e.drops = 0;
            sb.push_back(e);
        end
        check_output("cmd_ready_empty", cmd_ready, FIFO_EN);
        for (int j = 0; j < 8; j++) begin
            enable = 1'b1;
            if (j == 3) check_output("cmd_ready_three_used", cmd_ready, FIFO_EN);
            if (j == 4) check_output("cmd_ready_full", cmd_ready, 0);
            cmd_valid = (j < 5);
            cmd_data  = (j < 5) ? wr_bytes[j] : 8'h00;
            @(negedge clk320);
        end
        cmd_valid = 1'b0;
        apply_stimulus(FIFO_EN ? 8'h5A : IDLE, 4'd10, 0, 1'b1, 8'h00);
        check_output("cmd_ready_after_pop", cmd_ready, FIFO_EN);
        apply_stimulus(FIFO_EN ? 8'h3C : IDLE, 4'd11, 0, 1'b1, 8'h00);
        apply_stimulus(FIFO_EN ? 8'hF0 : IDLE, 4'd12, 0, 1'b1, 8'h00);
        apply_stimulus(FIFO_EN ? 8'h0F : IDLE, 4'd13, 0, 1'b1, 8'h00);
        apply_stimulus(IDLE, 4'd14, 0, 1'b1, 8'h00);

        // Build a trigger backlog, then reset at bit 3 of an L0L1 frame.
        $display("[TB] reset mid-frame");
        apply_stimulus(IDLE, 4'd15, 0, 1'b1, 8'h06);
        apply_stimulus(BCR,  4'd0,  0, 1'b1, 8'h00);
        apply_stimulus(L0L1, 4'd1,  0, 1'b1, 8'h02);
        for (int j = 0; j < 5; j++) begin
            enable = 1'b1;
            @(negedge clk320);
        end
        check_output("pre_rst_bc_cnt", bc_cnt, 2);
        #1;
        LPGBT_HARD_RSTB = 1'b0;
        #1;
        check_output("mid_rst_fast_cmd_out", fast_cmd_out, 0);
        check_output("mid_rst_frame_start", frame_start, 0);
        check_output("mid_rst_bc_cnt", bc_cnt, 0);
        check_output("mid_rst_trig_drop", trig_drop, 0);
        check_output("mid_rst_cmd_ready", cmd_ready, FIFO_EN);
        repeat (3) @(negedge clk320);
        LPGBT_HARD_RSTB = 1'b1;

        // After release: IDLE, then a fresh orbit with no residual L0L1,
        // then enable low returns bc to 0.
        apply_stimulus(IDLE, 4'd0, 0, 1'b1, 8'h00);
        apply_stimulus(BCR,  4'd0, 0, 1'b1, 8'h00);
        apply_stimulus(IDLE, 4'd1, 0, 1'b1, 8'h00);
        apply_stimulus(IDLE, 4'd2, 0, 1'b0, 8'h00);
        apply_stimulus(IDLE, 4'd0, 0, 1'b0, 8'h00);
        apply_stimulus(IDLE, 4'd0, 0, 1'b0, 8'h00);

        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk320);
        end
        check_output("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
